// File: rtl/pipe_rx_framer.sv
// PIPE receive framer: ordered-set detection plus TLP/DLLP byte extraction.
// Define PIPE_RX_STATS_EN to add saturating Ts1/Ts2/Skp/Err event counters.
module pipe_rx_framer #(
    parameter int unsigned MAX_TLP_BYTES = 4128
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [7:0]  RxData,
    input  logic        RxDataK,
    input  logic        RxValid,
    output logic [7:0]  PktData,
    output logic        PktValid,
    output logic        PktSop,
    output logic        PktEop,
    output logic        PktErr,
    output logic        PktDllp,
    output logic        Ts1Det,
    output logic        Ts2Det,
    output logic        SkpDet,
    output logic        FrameErr,
    output logic [7:0]  TsLinkNum,
    output logic [7:0]  TsLaneNum
`ifdef PIPE_RX_STATS_EN
    ,
    output logic [15:0] Ts1Count,
    output logic [15:0] Ts2Count,
    output logic [15:0] SkpCount,
    output logic [15:0] ErrCount
`endif
);
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] D_TS1 = 8'h4A;
    localparam logic [7:0] D_TS2 = 8'h45;

    localparam int CW0 = $clog2(MAX_TLP_BYTES + 1);
    localparam int CW  = (CW0 < 3) ? 3 : CW0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_TLP_BYTES);
    localparam logic [CW-1:0] DLLP_LEN = CW'(6);

    typedef enum logic [2:0] {
        IDLE, OS_HDR, OS_TS, OS_SKP, TLP, DLLP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic          first_q, first_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sym_q, sym_d;
    logic [7:0]    link_q, link_d;
    logic [7:0]    lane_q, lane_d;
    logic [7:0]    id_q, id_d;
    logic [7:0]    ts_link_q, ts_link_d;
    logic [7:0]    ts_lane_q, ts_lane_d;
    logic [7:0]    pkt_data_q, pkt_data_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          err_q, err_d;
    logic          dllp_q, dllp_d;
    logic          ts1_q, ts1_d;
    logic          ts2_q, ts2_d;
    logic          skp_q, skp_d;
    logic          ferr_q, ferr_d;

    logic redecode;
    logic emit;
    logic emit_eop;
    logic emit_err;
    logic id_ok;

    assign id_ok = !RxDataK && (RxData == D_TS1 || RxData == D_TS2)
                   && (sym_q == 4'd6 || RxData == id_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        first_d     = first_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        link_d      = link_q;
        lane_d      = lane_q;
        id_d        = id_q;
        ts_link_d   = ts_link_q;
        ts_lane_d   = ts_lane_q;
        pkt_data_d  = 8'h00;
        pkt_valid_d = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        err_d       = 1'b0;
        dllp_d      = 1'b0;
        ts1_d       = 1'b0;
        ts2_d       = 1'b0;
        skp_d       = 1'b0;
        ferr_d      = 1'b0;
        redecode    = 1'b0;
        emit        = 1'b0;
        emit_eop    = 1'b0;
        emit_err    = 1'b0;

        if (RxValid) begin
            unique case (state_q)
                IDLE: redecode = 1'b1;
                OS_HDR: begin
                    if (RxDataK && RxData == K_SKP) begin
                        state_d = OS_SKP;
                        skp_d   = 1'b1;
                    end else if (!RxDataK || RxData == K_PAD) begin
                        link_d  = RxData;
                        sym_d   = 4'd2;
                        state_d = OS_TS;
                    end else begin
                        state_d = IDLE;
                        ferr_d  = 1'b1;
                    end
                end
                OS_SKP: begin
                    if (!(RxDataK && RxData == K_SKP)) redecode = 1'b1;
                end
                OS_TS: begin
                    sym_d = sym_q + 4'd1;
                    if (sym_q == 4'd2) lane_d = RxData;
                    if (sym_q >= 4'd6) begin
                        id_d = RxData;
                        if (!id_ok) begin
                            state_d = IDLE;
                        end else if (sym_q == 4'd15) begin
                            ts1_d     = (RxData == D_TS1);
                            ts2_d     = (RxData == D_TS2);
                            ts_link_d = link_q;
                            ts_lane_d = lane_q;
                            state_d   = IDLE;
                        end
                    end
                end
                TLP, DLLP: begin
                    if (drop_q) begin
                        if (RxDataK && (RxData == K_END || RxData == K_EDB)) begin
                            state_d = IDLE;
                            drop_d  = 1'b0;
                        end
                    end else if (!RxDataK) begin
                        // The byte past the TLP limit closes the packet and is dropped
                        if (state_q == TLP && cnt_q == CNT_MAX) begin
                            emit       = hold_vld_q;
                            emit_eop   = 1'b1;
                            emit_err   = 1'b1;
                            hold_vld_d = 1'b0;
                            drop_d     = 1'b1;
                        end else begin
                            emit       = hold_vld_q;
                            hold_d     = RxData;
                            hold_vld_d = 1'b1;
                            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d    = IDLE;
                        hold_vld_d = 1'b0;
                        if (hold_vld_q) begin
                            emit     = 1'b1;
                            emit_eop = 1'b1;
                            emit_err = (RxData != K_END)
                                       || (state_q == DLLP && cnt_q != DLLP_LEN);
                        end else begin
                            ferr_d = 1'b1;
                        end
                        if (RxData != K_END && RxData != K_EDB) redecode = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (emit) begin
                pkt_valid_d = 1'b1;
                pkt_data_d  = hold_q;
                sop_d       = first_q;
                eop_d       = emit_eop;
                err_d       = emit_err;
                dllp_d      = (state_q == DLLP);
                first_d     = 1'b0;
            end

            if (redecode) begin
                state_d = IDLE;
                if (RxDataK && RxData == K_COM) state_d = OS_HDR;
                if (RxDataK && (RxData == K_STP || RxData == K_SDP)) begin
                    state_d    = (RxData == K_STP) ? TLP : DLLP;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b1;
                    cnt_d      = '0;
                    drop_d     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            first_q     <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            sym_q       <= 4'd0;
            link_q      <= 8'h00;
            lane_q      <= 8'h00;
            id_q        <= 8'h00;
            ts_link_q   <= 8'h00;
            ts_lane_q   <= 8'h00;
            pkt_data_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            dllp_q      <= 1'b0;
            ts1_q       <= 1'b0;
            ts2_q       <= 1'b0;
            skp_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            first_q     <= first_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            link_q      <= link_d;
            lane_q      <= lane_d;
            id_q        <= id_d;
            ts_link_q   <= ts_link_d;
            ts_lane_q   <= ts_lane_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
            dllp_q      <= dllp_d;
            ts1_q       <= ts1_d;
            ts2_q       <= ts2_d;
            skp_q       <= skp_d;
            ferr_q      <= ferr_d;
        end
    end

    assign PktData   = pkt_data_q;
    assign PktValid  = pkt_valid_q;
    assign PktSop    = sop_q;
    assign PktEop    = eop_q;
    assign PktErr    = err_q;
    assign PktDllp   = dllp_q;
    assign Ts1Det    = ts1_q;
    assign Ts2Det    = ts2_q;
    assign SkpDet    = skp_q;
    assign FrameErr  = ferr_q;
    assign TsLinkNum = ts_link_q;
    assign TsLaneNum = ts_lane_q;

`ifdef PIPE_RX_STATS_EN
    logic [15:0] ts1_cnt_q, ts1_cnt_d;
    logic [15:0] ts2_cnt_q, ts2_cnt_d;
    logic [15:0] skp_cnt_q, skp_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        ts1_cnt_d = ts1_cnt_q;
        ts2_cnt_d = ts2_cnt_q;
        skp_cnt_d = skp_cnt_q;
        err_cnt_d = err_cnt_q;
        if (ts1_d && ts1_cnt_q != 16'hFFFF) ts1_cnt_d = ts1_cnt_q + 16'd1;
        if (ts2_d && ts2_cnt_q != 16'hFFFF) ts2_cnt_d = ts2_cnt_q + 16'd1;
        if (skp_d && skp_cnt_q != 16'hFFFF) skp_cnt_d = skp_cnt_q + 16'd1;
        if ((err_d || ferr_d) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            ts1_cnt_q <= 16'h0000;
            ts2_cnt_q <= 16'h0000;
            skp_cnt_q <= 16'h0000;
            err_cnt_q <= 16'h0000;
        end else begin
            ts1_cnt_q <= ts1_cnt_d;
            ts2_cnt_q <= ts2_cnt_d;
            skp_cnt_q <= skp_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Ts1Count = ts1_cnt_q;
    assign Ts2Count = ts2_cnt_q;
    assign SkpCount = skp_cnt_q;
    assign ErrCount = err_cnt_q;
`endif
endmodule
